// File: rtl/ram_reader_pkg.sv
// ram_reader_pkg: shared state type, return-entry layout and latency limits
// for the burst reader and its return FIFO.
package ram_reader_pkg;
    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;
    localparam int RD_DATA_W      = 64;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_e;

    typedef struct packed {
        logic                 last;
        logic [RD_DATA_W-1:0] data;
    } rd_entry_t;
endpackage

// File: rtl/ram_reader_fifo.sv
// ram_reader_fifo: synchronous return buffer between the RAM read pipeline
// and the output stream; DEPTH must be a power of two.
module ram_reader_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                       clock0,
    input  logic                       aclr0_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;

    always_ff @(posedge clock0)
        if (i_push)
            r_mem[r_wp] <= i_wdata;

    always_ff @(posedge clock0 or negedge aclr0_n) begin
        if (!aclr0_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push)
                r_wp <= r_wp + AW'(1);
            if (i_pop)
                r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_rdata = r_mem[r_rp];
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;

    // Credit accounting upstream guarantees space for every in-flight read.
    assert property (@(posedge clock0) disable iff (!aclr0_n) !(i_push && o_full));
endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: issues one altsyncram read per cycle for a burst command,
// tracks the fixed read latency and streams the words out with a last marker.
module ram_burst_reader
    import ram_reader_pkg::*;
#(
    parameter int DATA_W     = RD_DATA_W,
    parameter int ADDR_W     = 9,
    parameter int LEN_W      = 10,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock0,
    input  logic              aclr0_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_e         r_state;
    rd_state_e         w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;
    logic [RD_LATENCY-1:0] r_vld;
    logic [RD_LATENCY-1:0] r_lst;
    logic [CW-1:0]     r_cred;
    logic [CW-1:0]     w_cnt;
    logic              w_issue;
    logic              w_load;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_done;
    logic [DATA_W:0]   w_head;

    assign w_load = cmd_valid && cmd_ready && cmd_len != '0;
    assign w_pop  = out_valid && out_ready;
    // Finish in the same cycle the final buffered word leaves, so busy drops right after.
    assign w_done = !(|r_vld) && (w_empty || (w_cnt == CW'(1) && w_pop));

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        w_issue   = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                w_next    = w_load ? ISSUE : IDLE;
            end
            ISSUE: begin
                w_issue = r_cred < CW'(FIFO_DEPTH);
                w_next  = (w_issue && r_rem == LEN_W'(1)) ? DRAIN : ISSUE;
            end
            DRAIN:   w_next = w_done ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock0 or negedge aclr0_n) begin
        if (!aclr0_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_vld   <= '0;
            r_lst   <= '0;
            r_cred  <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_addr <= cmd_addr;
                r_rem  <= cmd_len;
            end else if (w_issue) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_rem  <= r_rem - LEN_W'(1);
            end
            r_vld  <= RD_LATENCY'({r_vld, w_issue});
            r_lst  <= RD_LATENCY'({r_lst, w_issue && r_rem == LEN_W'(1)});
            r_cred <= r_cred + CW'(w_issue) - CW'(w_pop);
        end
    end

    ram_reader_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock0  (clock0),
        .aclr0_n (aclr0_n),
        .i_push  (r_vld[RD_LATENCY-1]),
        .i_wdata ({r_lst[RD_LATENCY-1], ram_q}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );

    assign ram_rden    = w_issue;
    assign ram_address = r_addr;
    assign busy        = r_state != IDLE;
    assign out_valid   = !w_empty;
    assign out_data    = w_head[DATA_W-1:0];
    assign out_last    = w_head[DATA_W] && !w_empty;

    assert property (@(posedge clock0)
        RD_LATENCY >= RD_LATENCY_MIN && RD_LATENCY <= RD_LATENCY_MAX && FIFO_DEPTH >= RD_LATENCY + 2);
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: scoreboard bench for ram_burst_reader at three
// latency/depth configurations, each with its own latency-accurate RAM model.
module tb_ram_burst_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid   [3];
    logic        cmd_ready   [3];
    logic [8:0]  cmd_addr    [3];
    logic [9:0]  cmd_len     [3];
    logic [8:0]  ram_address [3];
    logic        ram_rden    [3];
    logic [63:0] ram_q       [3];
    logic        out_valid   [3];
    logic        out_ready   [3];
    logic [63:0] out_data    [3];
    logic        out_last    [3];
    logic        busy        [3];
    logic [64:0] exp_q [3][$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        localparam int DEP = (g == 2) ? 8 : 4;
        logic [63:0] s [4];

        // RAM holds mem[i] = i; stage 0 captures on rden, later stages model output registers.
        always @(posedge clk) begin
            s[0] <= ram_rden[g] ? 64'(ram_address[g]) : s[0];
            for (int i = 1; i < 4; i++) s[i] <= s[i-1];
        end
        assign ram_q[g] = s[LAT-1];

        ram_burst_reader #(
            .DATA_W(64), .ADDR_W(9), .LEN_W(10), .RD_LATENCY(LAT), .FIFO_DEPTH(DEP)
        ) dut (
            .clock0(clk), .aclr0_n(rst_n),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
            .cmd_addr(cmd_addr[g]), .cmd_len(cmd_len[g]),
            .ram_address(ram_address[g]), .ram_rden(ram_rden[g]), .ram_q(ram_q[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .out_data(out_data[g]), .out_last(out_last[g]), .busy(busy[g])
        );

        always @(negedge clk) begin
            int n;
            if (rst_n && out_valid[g] && out_ready[g]) begin
                n = exp_q[g].size();
                if (n == 0) chk($sformatf("sb_underflow%0d", g), 65'(n), 65'(1));
                else chk($sformatf("sb_word%0d", g), {out_last[g], out_data[g]}, exp_q[g].pop_front());
            end
        end
    end

    task automatic push_exp(input int g, input int addr, input int len);
        for (int i = 0; i < len; i++)
            exp_q[g].push_back({(i == len - 1), 64'((addr + i) % 512)});
    endtask

    task automatic send(input int addr, input int len);
        push_exp(0, addr, len);
        cmd_addr[0]  = 9'(addr);
        cmd_len[0]   = 10'(len);
        cmd_valid[0] = 1'b1;
        @(negedge clk);
        chk("cmd_ready", 65'(cmd_ready[0]), 65'(1));
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int t = 0;
        while (busy[g] && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", 65'(busy[g]), 65'(0));
        chk("sb_left", 65'(exp_q[g].size()), 65'(0));
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_ready", 65'(cmd_ready[0]), 65'(1));
        chk("rst_rden", 65'(ram_rden[0]), 65'(0));
        chk("rst_address", 65'(ram_address[0]), 65'(0));
        chk("rst_valid", 65'(out_valid[0]), 65'(0));
        chk("rst_last", 65'(out_last[0]), 65'(0));
        chk("rst_busy", 65'(busy[0]), 65'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int t;
        int first [3];
        int lastk [3];
        int nv    [3];
        for (int g = 0; g < 3; g++) begin
            cmd_valid[g] = 1'b0;
            cmd_addr[g]  = '0;
            cmd_len[g]   = '0;
            out_ready[g] = 1'b1;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_n = 1'b1;

        // basic burst, cycle by cycle
        send(5, 4);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("basic_rden_c%0d", k), 65'(ram_rden[0]), 65'(k >= 1 && k <= 4));
            if (k <= 4) chk($sformatf("basic_addr_c%0d", k), 65'(ram_address[0]), 65'(4 + k));
            chk($sformatf("basic_valid_c%0d", k), 65'(out_valid[0]), 65'(k >= 4 && k <= 7));
            chk($sformatf("basic_last_c%0d", k), 65'(out_last[0]), 65'(k == 7));
            chk($sformatf("basic_busy_c%0d", k), 65'(busy[0]), 65'(k <= 7));
            @(posedge clk); #1;
        end

        // address wrap
        send(510, 4);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("wrap_rden_c%0d", k), 65'(ram_rden[0]), 65'(1));
            chk($sformatf("wrap_addr_c%0d", k), 65'(ram_address[0]), 65'((509 + k) % 512));
            @(posedge clk); #1;
        end
        wait_idle(0);

        // backpressure
        out_ready[0] = 1'b0;
        send(100, 16);
        cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ram_rden[0]) cnt++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("bp_reads", 65'(cnt), 65'(4));
        chk("bp_rden_off", 65'(ram_rden[0]), 65'(0));
        chk("bp_valid", 65'(out_valid[0]), 65'(1));
        chk("bp_data_stable", 65'(out_data[0]), 65'(100));
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        wait_idle(0);

        // zero length, then single word
        send(50, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("zero_cmd_ready", 65'(cmd_ready[0]), 65'(1));
            chk("zero_rden", 65'(ram_rden[0]), 65'(0));
            chk("zero_valid", 65'(out_valid[0]), 65'(0));
            chk("zero_busy", 65'(busy[0]), 65'(0));
            @(posedge clk); #1;
        end
        send(7, 1);
        wait_idle(0);

        // reset mid-burst
        send(200, 16);
        cnt = 0;
        t = 0;
        while (cnt < 3 && t < 20) begin
            @(negedge clk);
            if (ram_rden[0]) cnt++;
            t++;
        end
        chk("mid_reads_before_reset", 65'(cnt), 65'(3));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        exp_q[0].delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(300, 3);
        wait_idle(0);

        // latency sweep on RD_LATENCY=1 and 4
        push_exp(1, 0, 32);
        push_exp(2, 64, 32);
        cmd_addr[1] = 9'd0;  cmd_len[1] = 10'd32; cmd_valid[1] = 1'b1;
        cmd_addr[2] = 9'd64; cmd_len[2] = 10'd32; cmd_valid[2] = 1'b1;
        for (int g = 1; g < 3; g++) begin
            first[g] = 0;
            lastk[g] = 0;
            nv[g]    = 0;
        end
        @(posedge clk); #1;
        cmd_valid[1] = 1'b0;
        cmd_valid[2] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            for (int g = 1; g < 3; g++)
                if (out_valid[g]) begin
                    if (first[g] == 0) first[g] = k;
                    lastk[g] = k;
                    nv[g]++;
                end
            @(posedge clk); #1;
        end
        chk("sweep_lat1_first", 65'(first[1]), 65'(3));
        chk("sweep_lat4_first", 65'(first[2]), 65'(6));
        chk("sweep_lat1_span", 65'(lastk[1] - first[1] + 1), 65'(32));
        chk("sweep_lat4_span", 65'(lastk[2] - first[2] + 1), 65'(32));
        chk("sweep_lat1_count", 65'(nv[1]), 65'(32));
        chk("sweep_lat4_count", 65'(nv[2]), 65'(32));
        chk("sweep_lat1_busy", 65'(busy[1]), 65'(0));
        chk("sweep_lat4_busy", 65'(busy[2]), 65'(0));
        chk("sweep_lat1_left", 65'(exp_q[1].size()), 65'(0));
        chk("sweep_lat4_left", 65'(exp_q[2].size()), 65'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
